truth_table_checker: RTL and testbench



---
 rtl/gate_chk_pkg.sv | 19 +
 rtl/settle_counter.sv | 27 ++
 rtl/truth_table_checker.sv | 129 ++++++++++++
 tb/tb_truth_table_checker.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/gate_chk_pkg.sv
// Shared types and constants for the 2-input gate truth-table checkers.
package gate_chk_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    WAIT,
    SAMPLE,
    DONE
  } state_t;

  localparam logic [3:0] TRUTH_OR  = 4'b1110;
  localparam logic [3:0] TRUTH_AND = 4'b1000;
  localparam logic [3:0] TRUTH_XOR = 4'b0110;

  localparam int VEC_W = 2;
  localparam int CNT_W = 8;

endpackage

// File: rtl/settle_counter.sv
// Loadable down-counter; last is high while the count sits at 1.
module settle_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_value,
  output logic         last
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (en && count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign last = (count_reg == W'(1));

endmodule

// File: rtl/truth_table_checker.sv
// Sweeps {A,B} through all four vectors, samples a gate DUT after a settle
// interval and compares against an expected truth table.
module truth_table_checker
  import gate_chk_pkg::*;
#(
  parameter logic [3:0] TRUTH  = TRUTH_OR,
  parameter int         SETTLE = 4,
  parameter int         LOOPS  = 1,
  parameter int         ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             out,
  output logic             a,
  output logic             b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [VEC_W-1:0] first_fail_vec,
  output logic             first_fail_valid
);

  if (SETTLE < 1 || SETTLE > 255) begin : g_bad_settle
    $error("truth_table_checker: SETTLE must be in 1..255");
  end
  if (LOOPS < 1 || LOOPS > 255) begin : g_bad_loops
    $error("truth_table_checker: LOOPS must be in 1..255");
  end

  localparam logic [CNT_W-1:0] LAST_LOOP = CNT_W'(LOOPS - 1);

  state_t             state_reg, state_next;
  logic [VEC_W-1:0]   vec_reg;
  logic [CNT_W-1:0]   loop_reg;
  logic               cnt_load, cnt_en, cnt_last;
  logic               mismatch, last_vec, last_loop;
  logic [ERR_W-1:0]   err_next;

  settle_counter #(.W(CNT_W)) u_settle (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (cnt_load),
    .en         (cnt_en),
    .load_value (CNT_W'(SETTLE)),
    .last       (cnt_last)
  );

  assign mismatch  = (out != TRUTH[vec_reg]);
  assign last_vec  = (vec_reg == 2'd3);
  assign last_loop = (loop_reg == LAST_LOOP);
  // Saturating increment; Pass on the final compare must see this value.
  assign err_next  = (mismatch && err_count != '1) ? err_count + 1'b1 : err_count;

  always_comb begin
    state_next = state_reg;
    cnt_load   = 1'b0;
    cnt_en     = 1'b0;
    case (state_reg)
      IDLE:    if (start) state_next = DRIVE;
      DONE:    state_next = start ? DRIVE : IDLE;
      DRIVE: begin
        cnt_load   = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        cnt_en = 1'b1;
        if (cnt_last) state_next = SAMPLE;
      end
      SAMPLE:  state_next = (last_vec && last_loop) ? DONE : DRIVE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      vec_reg          <= '0;
      loop_reg         <= '0;
      a                <= 1'b0;
      b                <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      state_reg <= state_next;
      done      <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            busy             <= 1'b1;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
            vec_reg          <= '0;
            loop_reg         <= '0;
          end
        end
        DRIVE: begin
          a <= vec_reg[1];
          b <= vec_reg[0];
        end
        SAMPLE: begin
          err_count <= err_next;
          if (mismatch && !first_fail_valid) begin
            first_fail_vec   <= vec_reg;
            first_fail_valid <= 1'b1;
          end
          vec_reg <= vec_reg + 1'b1;
          if (last_vec) loop_reg <= loop_reg + 1'b1;
          if (last_vec && last_loop) begin
            busy <= 1'b0;
            done <= 1'b1;
            pass <= (err_next == '0);
            a    <= 1'b0;
            b    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_checker.sv
// Self-checking bench for truth_table_checker: table rows, random DUT
// responses with glitches, and hand-written multi-cycle corner cases.
module tb_truth_table_checker;
  import gate_chk_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // Instance 0: defaults (SETTLE=4, LOOPS=1), response from a lookup table.
  logic       start0 = 1'b0;
  logic       out0, a0, b0, busy0, done0, pass0, fval0;
  logic [7:0] err0;
  logic [1:0] fv0;
  logic [3:0] resp0 = TRUTH_OR;
  logic       glitch_en = 1'b0;
  logic       noise = 1'b0;
  int         phase0 = 0;
  assign out0 = resp0[{a0, b0}] ^ noise;

  // Instance 1: SETTLE=1, LOOPS=2 with an AND gate as DUT.
  logic       start1 = 1'b0;
  logic       out1, a1, b1, busy1, done1, pass1, fval1;
  logic [7:0] err1;
  logic [1:0] fv1;
  assign out1 = a1 & b1;

  // Instance 2: narrow error counter, output stuck at 0.
  logic       start2 = 1'b0;
  logic       out2, a2, b2, busy2, done2, pass2, fval2;
  logic [1:0] err2;
  logic [1:0] fv2;
  assign out2 = 1'b0;

  truth_table_checker u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .out(out0), .a(a0), .b(b0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .first_fail_vec(fv0), .first_fail_valid(fval0));

  truth_table_checker #(.TRUTH(TRUTH_OR), .SETTLE(1), .LOOPS(2)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .out(out1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_fail_vec(fv1), .first_fail_valid(fval1));

  truth_table_checker #(.TRUTH(TRUTH_OR), .SETTLE(1), .LOOPS(2), .ERR_W(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .out(out2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .first_fail_vec(fv2), .first_fail_valid(fval2));

  // Position inside the 6-cycle vector period of u0; 5 is the sample cycle.
  always @(posedge clk) phase0 <= (busy0 && phase0 != 5) ? phase0 + 1 : 0;
  always @(negedge clk) noise <= (glitch_en && phase0 != 5) ? 1'($urandom) : 1'b0;

  task automatic chk(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  // Reference: the checker's verdict is a pure function of how the response
  // table differs from the expected table, repeated once per sweep.
  function automatic void model(input logic [3:0] truth, input logic [3:0] resp,
                                input int loops, input int errmax,
                                output int err, output int fv, output int fval,
                                output int pass);
    err = 0; fv = 0; fval = 0;
    for (int l = 0; l < loops; l++)
      for (int v = 0; v < 4; v++)
        if (resp[v] != truth[v]) begin
          if (err < errmax) err++;
          if (fval == 0) begin fval = 1; fv = v; end
        end
    pass = (err == 0) ? 1 : 0;
  endfunction

  task automatic run0(input string tag, input logic [3:0] resp, input logic g,
                      input int e_err, input int e_fv, input int e_fval, input int e_pass,
                      input int repulse_at, input bit immediate, input bit chain_next);
    int cyc, got, seq, exp_seq;
    resp0 = resp;
    glitch_en = g;
    if (!immediate) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    chk({tag, " busy_rise"}, busy0, 1);
    chk({tag, " cleared"}, {err0, fval0, fv0, pass0}, 0);
    cyc = 0; got = 0; seq = 0;
    while (cyc < 200 && got == 0) begin
      @(negedge clk);
      cyc++;
      start0 = (cyc == repulse_at);
      if (cyc % 6 == 5) seq = (seq << 2) | int'({a0, b0});
      if (done0) got = 1;
    end
    start0 = 1'b0;
    glitch_en = 1'b0;
    exp_seq = 0;
    for (int v = 0; v < 4; v++) exp_seq = (exp_seq << 2) | v;
    chk({tag, " done_seen"}, got, 1);
    chk({tag, " done_cycle"}, cyc, 24);
    chk({tag, " err_count"}, err0, e_err);
    chk({tag, " first_fail_vec"}, fv0, e_fv);
    chk({tag, " first_fail_valid"}, fval0, e_fval);
    chk({tag, " pass"}, pass0, e_pass);
    chk({tag, " ab_sequence"}, seq, exp_seq);
    chk({tag, " idle_outputs"}, {busy0, a0, b0}, 0);
    $display("run %s: resp=%b err=%0d fv=%0d fval=%0d pass=%0d cycles=%0d",
             tag, resp, err0, fv0, fval0, pass0, cyc);
    if (!chain_next) begin
      @(negedge clk);
      chk({tag, " done_pulse_width"}, done0, 0);
      chk({tag, " results_held"}, {err0, fv0, fval0, pass0},
          {8'(e_err), 2'(e_fv), 1'(e_fval), 1'(e_pass)});
    end
  endtask

  typedef struct {
    logic [3:0] resp;
    logic       glitch;
    int         err;
    int         fv;
    int         fval;
    int         pass;
  } row_t;

  row_t tbl[6];

  initial begin
    int e_err, e_fv, e_fval, e_pass, cyc, c1, c2, no_done;
    logic [3:0] r;
    logic g;

    tbl[0] = '{TRUTH_OR,  1'b0, 0, 0, 0, 1};
    tbl[1] = '{4'b0000,   1'b0, 3, 1, 1, 0};
    tbl[2] = '{4'b1111,   1'b0, 1, 0, 1, 0};
    tbl[3] = '{TRUTH_XOR, 1'b0, 1, 3, 1, 0};
    tbl[4] = '{TRUTH_AND, 1'b1, 2, 1, 1, 0};
    tbl[5] = '{TRUTH_OR,  1'b1, 0, 0, 0, 1};

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset u0", {a0, b0, busy0, done0, pass0, err0, fv0, fval0}, 0);
    chk("reset u1", {a1, b1, busy1, done1, pass1, err1, fv1, fval1}, 0);
    chk("reset u2", {a2, b2, busy2, done2, pass2, err2, fv2, fval2}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++)
      run0($sformatf("tbl%0d", i), tbl[i].resp, tbl[i].glitch, tbl[i].err,
           tbl[i].fv, tbl[i].fval, tbl[i].pass, -1, 1'b0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      r = 4'($urandom);
      g = 1'($urandom);
      model(TRUTH_OR, r, 1, 255, e_err, e_fv, e_fval, e_pass);
      run0($sformatf("rnd%0d", i), r, g, e_err, e_fv, e_fval, e_pass, -1, 1'b0, 1'b0);
    end

    // Start in the Done cycle is accepted and clears the previous failure.
    run0("stuck1", 4'b1111, 1'b0, 1, 0, 1, 0, -1, 1'b0, 1'b1);
    run0("b2b_or", TRUTH_OR, 1'b0, 0, 0, 0, 1, -1, 1'b1, 1'b0);

    // Start while busy is ignored.
    run0("repulse", 4'b0000, 1'b0, 3, 1, 1, 0, 5, 1'b0, 1'b0);

    // Reset during WAIT of vector 10 aborts the run with no Done.
    resp0 = TRUTH_OR;
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (13) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrun_reset outputs", {a0, b0, busy0, done0, pass0, err0, fv0, fval0}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    no_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done0 || busy0) no_done++;
    end
    chk("midrun_reset no_done", no_done, 0);
    run0("after_reset", TRUTH_OR, 1'b0, 0, 0, 0, 1, -1, 1'b0, 1'b0);

    // Two sweeps with SETTLE=1 on u1 (AND gate) and u2 (saturating counter).
    @(negedge clk);
    start1 = 1'b1; start2 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; start2 = 1'b0;
    chk("u1 busy_rise", busy1, 1);
    cyc = 0; c1 = -1; c2 = -1;
    while (cyc < 200 && (c1 < 0 || c2 < 0)) begin
      @(negedge clk);
      cyc++;
      if (done1 && c1 < 0) c1 = cyc;
      if (done2 && c2 < 0) c2 = cyc;
    end
    model(TRUTH_OR, TRUTH_AND, 2, 255, e_err, e_fv, e_fval, e_pass);
    chk("u1 done_cycle", c1, 4 * 2 * (1 + 2));
    chk("u1 err_count", err1, e_err);
    chk("u1 first_fail_vec", fv1, e_fv);
    chk("u1 first_fail_valid", fval1, e_fval);
    chk("u1 pass", pass1, e_pass);
    $display("run u1_and: err=%0d fv=%0d pass=%0d cycles=%0d", err1, fv1, pass1, c1);
    model(TRUTH_OR, 4'b0000, 2, 3, e_err, e_fv, e_fval, e_pass);
    chk("u2 done_cycle", c2, 4 * 2 * (1 + 2));
    chk("u2 err_saturated", err2, e_err);
    chk("u2 first_fail_vec", fv2, e_fv);
    chk("u2 pass", pass2, e_pass);
    $display("run u2_sat: err=%0d fv=%0d pass=%0d cycles=%0d", err2, fv2, pass2, c2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
